// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-unit encodings: FSM states, ARF/DR/Mem select codes, output bundle
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_DECODE  = 3'd3,
    S_DR_CLR  = 3'd4,
    S_DR_LOAD = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [2:0] ARF_SEL_NONE = 3'b000;
  localparam logic [2:0] ARF_SEL_PC   = 3'b100;
  localparam logic [2:0] ARF_SEL_AR   = 3'b010;
  localparam logic [2:0] ARF_SEL_SP   = 3'b001;

  localparam logic [1:0] ARF_FUN_HOLD = 2'b00;
  localparam logic [1:0] ARF_FUN_INC  = 2'b01;

  localparam logic [1:0] ARF_OUT_PC = 2'b00;
  localparam logic [1:0] ARF_OUT_AR = 2'b10;

  localparam logic [1:0] DR_FUN_HOLD = 2'b00;
  localparam logic [1:0] DR_FUN_CLR  = 2'b01;
  localparam logic [1:0] DR_FUN_SHL  = 2'b10;

  localparam logic MEM_CS_ON  = 1'b0;
  localparam logic MEM_CS_OFF = 1'b1;

  typedef struct packed {
    logic [1:0] out_d_sel;
    logic [1:0] fun_sel;
    logic [2:0] reg_sel;
    logic       ir_write;
    logic       ir_lh;
    logic       mem_cs;
    logic       dr_e;
    logic [1:0] dr_fun_sel;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    out_d_sel:  ARF_OUT_PC,
    fun_sel:    ARF_FUN_HOLD,
    reg_sel:    ARF_SEL_NONE,
    ir_write:   1'b0,
    ir_lh:      1'b0,
    mem_cs:     MEM_CS_OFF,
    dr_e:       1'b0,
    dr_fun_sel: DR_FUN_HOLD,
    done:       1'b0
  };

  // Datapath control word issued while the FSM sits in state s.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_FETCH_L, S_FETCH_H: begin
        c.out_d_sel = ARF_OUT_PC;
        c.mem_cs    = MEM_CS_ON;
        c.ir_write  = 1'b1;
        c.ir_lh     = (s == S_FETCH_H);
        c.reg_sel   = ARF_SEL_PC;
        c.fun_sel   = ARF_FUN_INC;
      end
      S_DR_CLR: begin
        c.dr_e       = 1'b1;
        c.dr_fun_sel = DR_FUN_CLR;
      end
      S_DR_LOAD: begin
        c.out_d_sel  = ARF_OUT_AR;
        c.mem_cs     = MEM_CS_ON;
        c.dr_e       = 1'b1;
        c.dr_fun_sel = DR_FUN_SHL;
        c.reg_sel    = ARF_SEL_AR;
        c.fun_sel    = ARF_FUN_INC;
      end
      S_DONE:  c.done = 1'b1;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_control_unit.sv
// rtl/fetch_control_unit.sv - instruction fetch / decode / DR operand-load sequencer for the ALU datapath
module fetch_control_unit
  import ctrl_pkg::*;
#(
  parameter int         DR_BYTES    = 4,
  parameter logic [5:0] LOAD_OPCODE = 6'h10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic [15:0] IROut,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic        Busy,
  output logic        Done,
  output logic [5:0]  Opcode
);

  if (DR_BYTES < 1 || DR_BYTES > 4) begin : g_bad_dr_bytes
    $error("fetch_control_unit: DR_BYTES must be in 1..4");
  end

  localparam logic [1:0] LAST_BYTE = 2'(DR_BYTES - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] byte_count;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_out;
  logic       busy_q;
  logic       unused_ir;

  assign unused_ir = ^IROut[9:0];

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    next_state = Start ? S_FETCH_L : S_IDLE;
      S_FETCH_L: next_state = S_FETCH_H;
      S_FETCH_H: next_state = S_DECODE;
      S_DECODE:  next_state = (IROut[15:10] == LOAD_OPCODE) ? S_DR_CLR : S_DONE;
      S_DR_CLR:  next_state = S_DR_LOAD;
      S_DR_LOAD: next_state = (byte_count == LAST_BYTE) ? S_DONE : S_DR_LOAD;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Control word is registered from next_state so it lines up with the state it belongs to.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      byte_count <= 2'd0;
      Opcode     <= 6'd0;
      ctrl_q     <= CTRL_IDLE;
      busy_q     <= 1'b0;
    end else if (!Stall) begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state);
      busy_q <= (next_state != S_IDLE);
      if (state == S_DECODE) begin
        Opcode <= IROut[15:10];
      end
      if (state == S_DR_CLR) begin
        byte_count <= 2'd0;
      end else if (state == S_DR_LOAD) begin
        byte_count <= byte_count + 2'd1;
      end
    end
  end

  // Stall masks the enables in the same cycle, so the held state reissues its word afterwards.
  assign ctrl_out = Stall ? CTRL_IDLE : ctrl_q;

  assign ARF_OutDSel = ctrl_out.out_d_sel;
  assign ARF_FunSel  = ctrl_out.fun_sel;
  assign ARF_RegSel  = ctrl_out.reg_sel;
  assign IR_Write    = ctrl_out.ir_write;
  assign IR_LH       = ctrl_out.ir_lh;
  assign Mem_CS      = ctrl_out.mem_cs;
  assign Mem_WR      = 1'b0;
  assign DR_E        = ctrl_out.dr_e;
  assign DR_FunSel   = ctrl_out.dr_fun_sel;
  assign Done        = ctrl_out.done;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_fetch_control_unit.sv
// tb/tb_fetch_control_unit.sv - self-checking bench: cycle table, corner sequences, random fetches vs datapath model
module tb_fetch_control_unit;

  // {Busy, Done, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E, DR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel}
  localparam logic [15:0] O_IDLE = 16'b0_0_1_0_0_0_0_00_000_00_00;
  localparam logic [15:0] O_FL   = 16'b1_0_0_0_1_0_0_00_100_01_00;
  localparam logic [15:0] O_FH   = 16'b1_0_0_0_1_1_0_00_100_01_00;
  localparam logic [15:0] O_HOLD = 16'b1_0_1_0_0_0_0_00_000_00_00;
  localparam logic [15:0] O_CLR  = 16'b1_0_1_0_0_0_1_01_000_00_00;
  localparam logic [15:0] O_LD   = 16'b1_0_0_0_0_0_1_10_010_01_10;
  localparam logic [15:0] O_DONE = 16'b1_1_1_0_0_0_0_00_000_00_00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  stall;
  logic [1:0]  set_req;
  logic [15:0] set_pc, set_ar;
  logic [31:0] set_dr;
  logic [7:0]  mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : dp
    logic [1:0]  out_sel, fun_sel, dr_fun;
    logic [2:0]  reg_sel;
    logic        ir_write, ir_lh, mem_cs, mem_wr, dr_e, busy, done;
    logic [5:0]  opcode;
    logic [15:0] pc, ar, ir;
    logic [31:0] dr;
    logic [7:0]  mo;

    fetch_control_unit #(.DR_BYTES(g == 0 ? 4 : 2), .LOAD_OPCODE(6'h10)) u_dut (
      .Clock(clk), .Reset(rst_n), .Start(start[g]), .Stall(stall[g]), .IROut(ir),
      .ARF_OutDSel(out_sel), .ARF_FunSel(fun_sel), .ARF_RegSel(reg_sel),
      .IR_Write(ir_write), .IR_LH(ir_lh), .Mem_CS(mem_cs), .Mem_WR(mem_wr),
      .DR_E(dr_e), .DR_FunSel(dr_fun), .Busy(busy), .Done(done), .Opcode(opcode)
    );

    assign mo = (mem_cs == 1'b0) ? mem[(out_sel == 2'b10) ? ar[7:0] : pc[7:0]] : 8'h00;

    always @(posedge clk) begin
      if (set_req[g]) begin
        pc <= set_pc;
        ar <= set_ar;
        dr <= set_dr;
        ir <= 16'h0000;
      end else begin
        if (ir_write) begin
          if (ir_lh) ir[15:8] <= mo;
          else       ir[7:0]  <= mo;
        end
        if (reg_sel[2] && fun_sel == 2'b01) pc <= pc + 16'd1;
        if (reg_sel[1] && fun_sel == 2'b01) ar <= ar + 16'd1;
        if (dr_e && dr_fun == 2'b01) dr <= 32'd0;
        if (dr_e && dr_fun == 2'b10) dr <= {dr[23:0], mo};
      end
    end
  end

  function automatic logic [15:0] outs0();
    return {dp[0].busy, dp[0].done, dp[0].mem_cs, dp[0].mem_wr, dp[0].ir_write, dp[0].ir_lh,
            dp[0].dr_e, dp[0].dr_fun, dp[0].reg_sel, dp[0].fun_sel, dp[0].out_sel};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preset(input int g, input logic [15:0] p, input logic [15:0] a, input logic [31:0] d);
    set_pc = p; set_ar = a; set_dr = d;
    set_req[g] = 1'b1;
    @(negedge clk);
    set_req[g] = 1'b0;
  endtask

  // One fetch on instance 0. mask[n] stalls step n+1; lat counts unstalled steps up to Done.
  task automatic fetch0(input logic [31:0] mask, output int lat, output int total, output int viol);
    logic [15:0] pc_prev;
    lat = 1; total = 1; viol = 0;
    start[0] = 1'b1; stall[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    pc_prev = dp[0].pc;
    while (dp[0].done !== 1'b1 && total < 64) begin
      stall[0] = (total < 32) ? mask[total] : 1'b0;
      @(negedge clk);
      total++;
      if (!stall[0]) lat++;
      else if (dp[0].ir_write || dp[0].dr_e || dp[0].reg_sel != 3'b000 ||
               dp[0].pc != pc_prev || dp[0].busy !== 1'b1) viol++;
      pc_prev = dp[0].pc;
    end
    stall[0] = 1'b0;
    if (dp[0].done !== 1'b1) lat = -1;
  endtask

  typedef struct packed {
    logic        start;
    logic        stall;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int lat, total, viol, n, errs;
    logic [15:0] p, a, ir_e, ar_e;
    logic [31:0] d0, dr_e_v;
    logic        is_load;

    tbl[0]  = {1'b0, 1'b0, O_IDLE};
    tbl[1]  = {1'b1, 1'b0, O_FL};
    tbl[2]  = {1'b1, 1'b0, O_FH};
    tbl[3]  = {1'b0, 1'b0, O_HOLD};
    tbl[4]  = {1'b0, 1'b0, O_CLR};
    tbl[5]  = {1'b0, 1'b0, O_LD};
    tbl[6]  = {1'b0, 1'b1, O_HOLD};
    tbl[7]  = {1'b0, 1'b0, O_LD};
    tbl[8]  = {1'b0, 1'b0, O_LD};
    tbl[9]  = {1'b0, 1'b0, O_LD};
    tbl[10] = {1'b1, 1'b0, O_DONE};
    tbl[11] = {1'b0, 1'b0, O_IDLE};
    tbl[12] = {1'b0, 1'b0, O_IDLE};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
    mem[8'h20] = 8'h00; mem[8'h21] = 8'h40;
    mem[8'h40] = 8'h34; mem[8'h41] = 8'h12;

    rst_n = 1'b0; start = 2'b00; stall = 2'b00; set_req = 2'b00;
    set_pc = 16'd0; set_ar = 16'd0; set_dr = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {16'd0, outs0()}, {16'd0, O_IDLE});
    chk("reset_opcode", {26'd0, dp[0].opcode}, 32'd0);
    chk("reset_inst1", {29'd0, dp[1].busy, dp[1].mem_cs, dp[1].done}, {29'd0, 3'b010});
    rst_n = 1'b1;
    @(negedge clk);

    // Load-opcode fetch, cycle by cycle, with one stall inside DR_LOAD.
    preset(0, 16'h0020, 16'h0000, 32'h12345678);
    for (int i = 0; i < 13; i++) begin
      start[0] = tbl[i].start;
      stall[0] = tbl[i].stall;
      @(negedge clk);
      chk($sformatf("table_step%0d", i), {16'd0, outs0()}, {16'd0, tbl[i].exp});
    end
    start[0] = 1'b0; stall[0] = 1'b0;
    chk("table_dr", dp[0].dr, 32'hAABBCCDD);
    chk("table_ar", {16'd0, dp[0].ar}, 32'd4);
    chk("table_pc", {16'd0, dp[0].pc}, 32'h22);
    chk("table_opcode", {26'd0, dp[0].opcode}, 32'h10);

    // Non-load fetch: low byte then high byte, Done four cycles after Start.
    preset(0, 16'h0040, 16'h0080, 32'h0BADF00D);
    start[0] = 1'b1;
    @(negedge clk);
    chk("t2_fetch_low", {16'd0, outs0()}, {16'd0, O_FL});
    start[0] = 1'b0;
    @(negedge clk);
    chk("t2_fetch_high", {16'd0, outs0()}, {16'd0, O_FH});
    @(negedge clk);
    @(negedge clk);
    chk("t2_done_at_4", {16'd0, outs0()}, {16'd0, O_DONE});
    @(negedge clk);
    chk("t2_done_one_cycle", {16'd0, outs0()}, {16'd0, O_IDLE});
    chk("t2_ir", {16'd0, dp[0].ir}, 32'h1234);
    chk("t2_opcode", {26'd0, dp[0].opcode}, 32'h04);
    chk("t2_pc", {16'd0, dp[0].pc}, 32'h42);
    chk("t2_dr_kept", dp[0].dr, 32'h0BADF00D);

    // Three stalled cycles while in FETCH_H.
    preset(0, 16'h0040, 16'h0080, 32'h0);
    fetch0(32'h0000_001C, lat, total, viol);
    chk("t5_total_cycles", total, 7);
    chk("t5_active_cycles", lat, 4);
    chk("t5_stall_quiet", viol, 0);
    chk("t5_ir", {16'd0, dp[0].ir}, 32'h1234);
    chk("t5_pc", {16'd0, dp[0].pc}, 32'h42);

    // DR_BYTES=2 instance: clear then two shifts.
    preset(1, 16'h0020, 16'h0000, 32'hFFFFFFFF);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    n = 1;
    while (dp[1].done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t4_latency", n, 7);
    chk("t4_dr", dp[1].dr, 32'h0000AABB);
    chk("t4_ar", {16'd0, dp[1].ar}, 32'd2);
    @(negedge clk);

    // Start held high: a fetch every five cycles, Done one cycle wide.
    for (int i = 0; i < 8; i++) mem[8'h60 + i] = 8'h00;
    preset(0, 16'h0060, 16'h0000, 32'h0);
    errs = 0;
    start[0] = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      if (dp[0].done !== ((s % 5) == 4) || dp[0].busy !== ((s % 5) != 0)) errs++;
    end
    start[0] = 1'b0;
    @(negedge clk);
    chk("t6_hold_start_pattern", errs, 0);
    chk("t6_pc", {16'd0, dp[0].pc}, 32'h68);
    chk("t6_idle_after", {31'd0, dp[0].busy}, 32'd0);

    // Asynchronous reset in the middle of DR_LOAD.
    preset(0, 16'h0020, 16'h0000, 32'h0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_in_load", {16'd0, outs0()}, {16'd0, O_LD});
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_reset_ctrl", {28'd0, dp[0].busy, dp[0].mem_cs, dp[0].dr_e, dp[0].done}, {28'd0, 4'b0100});
    chk("t1_reset_opcode", {26'd0, dp[0].opcode}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Random fetches with random stalls against the datapath-level model.
    for (int it = 0; it < 30; it++) begin
      p = 16'($urandom_range(0, 240));
      a = 16'($urandom_range(0, 250));
      d0 = $urandom;
      for (int k = 0; k < 4; k++) mem[8'(a + 16'(k))] = 8'($urandom);
      mem[p[7:0]] = 8'($urandom);
      mem[8'(p + 16'd1)] = ($urandom_range(0, 1) == 1) ? {6'h10, 2'($urandom)} : 8'($urandom);
      ir_e = {mem[8'(p + 16'd1)], mem[p[7:0]]};
      is_load = (ir_e[15:10] == 6'h10);
      dr_e_v = is_load ? {mem[8'(a)], mem[8'(a + 16'd1)], mem[8'(a + 16'd2)], mem[8'(a + 16'd3)]} : d0;
      ar_e = is_load ? a + 16'd4 : a;
      preset(0, p, a, d0);
      fetch0($urandom & $urandom, lat, total, viol);
      chk($sformatf("rnd%0d_latency", it), lat, is_load ? 9 : 4);
      chk($sformatf("rnd%0d_stall_quiet", it), viol, 0);
      chk($sformatf("rnd%0d_ir", it), {16'd0, dp[0].ir}, {16'd0, ir_e});
      chk($sformatf("rnd%0d_opcode", it), {26'd0, dp[0].opcode}, {26'd0, ir_e[15:10]});
      chk($sformatf("rnd%0d_pc", it), {16'd0, dp[0].pc}, {16'd0, p + 16'd2});
      chk($sformatf("rnd%0d_ar", it), {16'd0, dp[0].ar}, {16'd0, ar_e});
      chk($sformatf("rnd%0d_dr", it), dp[0].dr, dr_e_v);
      @(negedge clk);
      chk($sformatf("rnd%0d_idle", it), {16'd0, outs0()}, {16'd0, O_IDLE});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
